// File: rtl/dm_pkg.sv
// dm_pkg: shared types and constants for the data-memory responder.
//   state_t     - responder FSM states (IDLE / WAIT / RESP)
//   rsp_src_t   - selects which source drives the response data
//   BE_W/DATA_W - byte-enable and data widths of the memory bus
//   DM_DEPTH    - default number of implemented words
//   MMIO_OFFSET - word address of the MMIO register (equal to DEPTH)
//   be_merge()  - byte-enable merge of new data into an old word
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_RAM,
        SRC_MMIO
    } rsp_src_t;

    localparam int unsigned BE_W        = 4;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned DM_DEPTH    = 128;
    localparam int unsigned MMIO_OFFSET = DM_DEPTH;

    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// dm_responder_if: CPU data-memory request/response bus.
//   Request channel : req_valid, req_ready, req_we, req_be, req_addr, req_wdata
//   Response channel: rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   modport master - CPU memory stage (drives requests, accepts responses)
//   modport slave  - memory responder
interface dm_responder_if #(
    parameter int unsigned ADDR_W = 8
);
    import dm_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [BE_W-1:0]   req_be;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dm_ram.sv
// dm_ram: single-port word RAM, byte-enable write, synchronous read, no reset.
//   clk   - clock, rising edge
//   we    - write strobe (bytes selected by be)
//   re    - read strobe; rdata updates only when re=1 and holds otherwise
//   addr  - word index (caller guarantees addr < DEPTH when strobing)
//   be    - byte enables, bit i -> bits 8i+7:8i
//   wdata - write data
//   rdata - registered read data
module dm_ram
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH = DM_DEPTH,
    parameter int unsigned AW    = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: memory-side responder for the CPU data-memory bus.
// Accepts one request at a time, waits WAIT_CYC cycles, performs the access,
// then holds the response until the CPU takes it.
//   clk      - clock, rising edge
//   rstn     - asynchronous active-low reset
//   bus      - dm_responder_if.slave (request and response handshakes)
//   mmio_out - MMIO register value (0 unless DM_MMIO_EN is defined)
// Build option: define DM_MMIO_EN to map word address DEPTH to a 32-bit
// read/write register driving mmio_out; otherwise that address is out of range.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = DM_DEPTH,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rstn,
    dm_responder_if.slave     bus,
    output logic [DATA_W-1:0] mmio_out
);

    localparam int unsigned       RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    rsp_src_t          src_q;
    logic [DATA_W-1:0] mmio_q;
    logic [DATA_W-1:0] ram_rdata;

    logic access;
    logic in_range;
    logic mmio_hit;

    assign access   = (state == WAIT) && (cnt == 4'd0);
    assign in_range = ({1'b0, addr_q} < DEPTH_W);
`ifdef DM_MMIO_EN
    assign mmio_hit = ({1'b0, addr_q} == DEPTH_W);
`else
    assign mmio_hit = 1'b0;
`endif

    dm_ram #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (access && in_range && we_q),
        .re    (access && in_range && !we_q),
        .addr  (addr_q[RAM_AW-1:0]),
        .be    (be_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            src_q       <= SRC_ZERO;
            mmio_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        be_q    <= bus.req_be;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        cnt     <= 4'(WAIT_CYC);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                        if (in_range) begin
                            rsp_err_q <= 1'b0;
                            src_q     <= we_q ? SRC_ZERO : SRC_RAM;
                        end else if (mmio_hit) begin
                            rsp_err_q <= 1'b0;
                            src_q     <= we_q ? SRC_ZERO : SRC_MMIO;
                            if (we_q) begin
                                mmio_q <= be_merge(mmio_q, wdata_q, be_q);
                            end
                        end else begin
                            rsp_err_q <= 1'b1;
                            src_q     <= SRC_ZERO;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Load data is not copied into a response register: the RAM output
    // register is only strobed on the access edge and holds until the next
    // load, so a registered source select yields a stable, reset-safe rdata.
    always_comb begin
        bus.rsp_rdata = '0;
        case (src_q)
            SRC_RAM:  bus.rsp_rdata = ram_rdata;
            SRC_MMIO: bus.rsp_rdata = mmio_q;
            default:  bus.rsp_rdata = '0;
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;

`ifdef DM_MMIO_EN
    assign mmio_out = mmio_q;
`else
    assign mmio_out = '0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed self-checking bench for dm_responder
// (ADDR_W=8, DEPTH=128, WAIT_CYC=2). Expectations follow DM_MMIO_EN.
module tb_dm_responder;
    import dm_pkg::*;

    logic        clk;
    logic        rstn;
    logic [31:0] mmio_out;

    int n_checks;
    int n_fail;

    dm_responder_if #(.ADDR_W(8)) bus ();

    dm_responder #(
        .ADDR_W   (8),
        .DEPTH    (128),
        .WAIT_CYC (2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .mmio_out (mmio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with rsp_ready held high. lat = cycles from accept
    // edge to rsp_valid, -1 on timeout (timeouts are counted as failures).
    task automatic do_req(input logic we, input logic [3:0] be,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat);
        logic rdy;
        bit   ok;
        rdata = '0;
        err   = 1'b0;
        lat   = -1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_be    = be;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            rdy = bus.req_ready;
            step();
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        bus.req_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout addr=%h: req_ready never seen", addr);
            return;
        end
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.rsp_valid) begin
                lat   = i;
                rdata = bus.rsp_rdata;
                err   = bus.rsp_err;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout addr=%h: rsp_valid never seen", addr);
            return;
        end
        step();
    endtask

    task automatic test_reset();
        rstn          = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_be    = 4'hF;
        bus.req_addr  = 8'h01;
        bus.req_wdata = 32'h1111_1111;
        bus.rsp_ready = 1'b1;
        repeat (3) step();
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
            bus.rsp_rdata !== 32'h0 || mmio_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b err=%b rdata=%h mmio=%h, want 0/0/0/0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, mmio_out);
        end
        bus.req_valid = 1'b0;
        rstn = 1'b1;
        step();
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: req_ready=%b rsp_valid=%b, want 1/0",
                     bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_timing();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 4'hF, 8'h05, 32'hDEAD_BEEF, rd, er, lat);
        n_checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL store_timing: lat=%0d err=%b rdata=%h, want 3/0/00000000", lat, er, rd);
        end
        do_req(1'b0, 4'h0, 8'h05, 32'h0, rd, er, lat);
        n_checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL load_timing: lat=%0d err=%b rdata=%h, want 3/0/deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 4'b0010, 8'h05, 32'h0000_AA00, rd, er, lat);
        do_req(1'b0, 4'h0, 8'h05, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'hDEAD_AAEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_enable: rdata=%h err=%b, want deadaaef/0", rd, er);
        end
        do_req(1'b1, 4'b0000, 8'h05, 32'hFFFF_FFFF, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 32'h0 || lat !== 3) begin
            n_fail++;
            $display("FAIL be_zero_store: err=%b rdata=%h lat=%0d, want 0/0/3", er, rd, lat);
        end
        do_req(1'b0, 4'hF, 8'h05, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'hDEAD_AAEF) begin
            n_fail++;
            $display("FAIL be_zero_unchanged: rdata=%h, want deadaaef", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          seen;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_be    = 4'h0;
        bus.req_addr  = 8'h05;
        bus.req_wdata = 32'h0;
        step();                      // accepted on this edge (state was IDLE)
        bus.req_we    = 1'b1;        // second request, held by the CPU
        bus.req_be    = 4'hF;
        bus.req_addr  = 8'h06;
        bus.req_wdata = 32'h0606_0606;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.rsp_valid) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL bp_rsp_timeout: rsp_valid=%b, want 1", bus.rsp_valid);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_AAEF ||
                bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid=%b rdata=%h err=%b req_ready=%b, want 1/deadaaef/0/0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
            end
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: rsp_valid=%b req_ready=%b, want 0/1",
                     bus.rsp_valid, bus.req_ready);
        end
        step();                      // second request accepted here
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second_accept: req_ready=%b, want 0", bus.req_ready);
        end
        repeat (3) step();           // WAIT_CYC+1 cycles to response
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second_rsp: rsp_valid=%b err=%b, want 1/0", bus.rsp_valid, bus.rsp_err);
        end
        step();
        do_req(1'b0, 4'h0, 8'h06, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h0606_0606) begin
            n_fail++;
            $display("FAIL bp_second_data: rdata=%h, want 06060606", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 4'hF, 8'h40, 32'h4040_4040, rd, er, lat);
        do_req(1'b1, 4'hF, 8'h00, 32'h00C0_FFEE, rd, er, lat);
        do_req(1'b1, 4'hF, 8'hC0, 32'hBADB_AD01, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_store_c0: err=%b rdata=%h, want 1/0", er, rd);
        end
        do_req(1'b0, 4'h0, 8'hC0, 32'h0, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_load_c0: err=%b rdata=%h, want 1/0", er, rd);
        end
`ifndef DM_MMIO_EN
        do_req(1'b1, 4'hF, 8'h80, 32'hBADB_AD02, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0 || mmio_out !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_store_80: err=%b rdata=%h mmio=%h, want 1/0/0", er, rd, mmio_out);
        end
`endif
        do_req(1'b0, 4'h0, 8'h40, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h4040_4040 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_alias_40: rdata=%h err=%b, want 40404040/0", rd, er);
        end
        do_req(1'b0, 4'h0, 8'h00, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h00C0_FFEE || er !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_alias_00: rdata=%h err=%b, want 00c0ffee/0", rd, er);
        end
    endtask

    task automatic test_mmio();
`ifdef DM_MMIO_EN
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 4'hF, 8'h80, 32'hA5A5_A5A5, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || mmio_out !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL mmio_store: err=%b mmio=%h, want 0/a5a5a5a5", er, mmio_out);
        end
        do_req(1'b1, 4'b0001, 8'h80, 32'h0000_003C, rd, er, lat);
        do_req(1'b0, 4'h0, 8'h80, 32'h0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 32'hA5A5_A53C || mmio_out !== 32'hA5A5_A53C) begin
            n_fail++;
            $display("FAIL mmio_load_be: err=%b rdata=%h mmio=%h, want 0/a5a5a53c/a5a5a53c",
                     er, rd, mmio_out);
        end
`else
        n_checks++;
        if (mmio_out !== 32'h0) begin
            n_fail++;
            $display("FAIL mmio_tied: mmio=%h, want 0", mmio_out);
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 4'hF, 8'h07, 32'h1111_2222, rd, er, lat);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_be    = 4'hF;
        bus.req_addr  = 8'h07;
        bus.req_wdata = 32'h1234_5678;
        step();                      // accepted; now in WAIT with cnt=2
        bus.req_valid = 1'b0;
        rstn = 1'b0;
        step();
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || mmio_out !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_state: rsp_valid=%b req_ready=%b mmio=%h, want 0/1/0",
                     bus.rsp_valid, bus.req_ready, mmio_out);
        end
        rstn = 1'b1;
        step();
        do_req(1'b0, 4'h0, 8'h07, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h1111_2222 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_dropped: rdata=%h err=%b, want 11112222/0", rd, er);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_timing();
        test_byte_enables();
        test_backpressure();
        test_out_of_range();
        test_mmio();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
